bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_add.sv | 27 ++
 rtl/bcd_serial_adder.sv | 133 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types for the serial BCD adder: FSM states, BCD digit type and digit limit.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder with decimal correction; flags any input digit above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout,
    output logic       invalid
);
    logic [4:0] s;
    logic [4:0] s_adj;

    always_comb begin
        s       = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        s_adj   = s + 5'd6;
        invalid = (a > BCD_MAX) || (b > BCD_MAX);
        if (s > {1'b0, BCD_MAX}) begin
            digit = s_adj[3:0];
            cout  = 1'b1;
        end else begin
            digit = s[3:0];
            cout  = 1'b0;
        end
    end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, one digit per clock, ones digit first.
// Define BCD_SUB_EN to add the sub input / neg output (nines-complement subtract).
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
`ifdef BCD_SUB_EN
    input  logic                    sub,
    output logic                    neg,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*(DIGITS+1)-1:0] sum,
    output logic                    err
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e                      state_q, state_d;
    bcd_digit_t [DIGITS-1:0]     a_q, a_d, b_q, b_d;
    bcd_digit_t [DIGITS-1:0]     res_q, res_d;
    bcd_digit_t [DIGITS:0]       sum_q, sum_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        carry_q, carry_d;
    logic                        err_q, err_d;
    logic                        sub_q, sub_d;
    logic                        neg_q, neg_d;
    logic                        sub_in;
    logic                        accept;
    bcd_digit_t                  dig_a, dig_b, dig_sum;
    logic                        dig_cout, dig_inv;

    bcd_digit_add u_digit (
        .a       (dig_a),
        .b       (dig_b),
        .cin     (carry_q),
        .digit   (dig_sum),
        .cout    (dig_cout),
        .invalid (dig_inv)
    );

`ifdef BCD_SUB_EN
    assign sub_in = sub;
    assign neg    = neg_q;
`else
    assign sub_in = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        err_d   = err_q;
        sub_d   = sub_q;
        neg_d   = neg_q;
        dig_a   = a_q[idx_q];
        // Subtract adds the nines complement; an out-of-range b digit still lands above 9.
        dig_b   = sub_q ? (BCD_MAX - b_q[idx_q]) : b_q[idx_q];

        case (state_q)
            RUN: begin
                res_d[idx_q] = dig_sum;
                carry_d      = dig_cout;
                err_d        = err_q | dig_inv;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    sum_d   = {(sub_q ? 4'd0 : {3'd0, dig_cout}), res_d};
                    neg_d   = sub_q & ~dig_cout;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) state_d = IDLE;
            end
            default: ;
        endcase

        // Acceptance from DONE overrides the return to IDLE for back-to-back operation.
        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            sub_d   = sub_in;
            idx_d   = '0;
            carry_d = sub_in;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            sub_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            sub_q   <= sub_d;
            neg_q   <= neg_d;
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: directed cases plus random operands vs a decimal model.
module tb_bcd_serial_adder;
    localparam int D = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               in_ready, out_valid, err_o;
    logic [4*D-1:0]     a_i = '0, b_i = '0;
    logic [4*(D+1)-1:0] sum_o;
`ifdef BCD_SUB_EN
    logic               sub_i = 1'b0;
    logic               neg_o;
`endif

    typedef struct {
        logic [4*(D+1)-1:0] sum;
        bit                 err;
        bit                 neg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
`ifdef BCD_SUB_EN
        .sub       (sub_i),
        .neg       (neg_o),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum_o),
        .err       (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
        end
    endtask

    // Decimal reference: operands as integers, result re-encoded as BCD.
    function automatic exp_t model(input logic [4*D-1:0] ta, input logic [4*D-1:0] tb, input bit ts);
        exp_t e;
        int va, vb, r, p, da, db;
        va = 0; vb = 0; p = 1;
        e.err = 0; e.neg = 0; e.sum = '0;
        for (int i = 0; i < D; i++) begin
            da = int'(ta[4*i +: 4]);
            db = int'(tb[4*i +: 4]);
            if (da > 9 || db > 9) e.err = 1;
            va += da * p;
            vb += db * p;
            p  *= 10;
        end
        if (ts) begin
            if (va >= vb) r = va - vb;
            else begin
                r = p - (vb - va);
                e.neg = 1;
            end
        end else r = va + vb;
        for (int i = 0; i <= D; i++) begin
            e.sum[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) exp_q.delete();
        else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result got=%0h exp=none", sum_o);
            end else begin
                e = exp_q.pop_front();
                chk("err", {31'd0, err_o}, {31'd0, e.err});
                if (!e.err) chk("sum", 32'(sum_o), 32'(e.sum));
`ifdef BCD_SUB_EN
                if (!e.err) chk("neg", {31'd0, neg_o}, {31'd0, e.neg});
`endif
            end
        end
    end

    task automatic send(input logic [4*D-1:0] ta, input logic [4*D-1:0] tb, input bit ts, input bit rnd);
        bit done;
        int n;
        done = 0; n = 0;
        a_i = ta; b_i = tb; in_valid = 1'b1;
`ifdef BCD_SUB_EN
        sub_i = ts;
`endif
        while (!done && n < 60) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(ta, tb, ts));
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done && rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1, c2, n;
        logic [4*D-1:0] ra, rb;
        bit rs;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_sum", 32'(sum_o), 0);
        chk("rst_err", {31'd0, err_o}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_in_ready", {31'd0, in_ready}, 1);

        // 77+64: result exactly DIGITS edges after acceptance
        out_ready = 1'b1;
        send(8'h77, 8'h64, 0, 0);
        chk("lat_e0", {31'd0, out_valid}, 0);
        @(posedge clk); #1 chk("lat_e1", {31'd0, out_valid}, 0);
        @(posedge clk); #1 chk("lat_e2", {31'd0, out_valid}, 1);
        chk("lat_sum", 32'(sum_o), 32'h141);
        wait_idle();

        // back-to-back with no bubble
        send(8'h76, 8'h55, 0, 0);
        c1 = acc_cyc;
        send(8'h43, 8'h99, 0, 0);
        c2 = acc_cyc;
        chk("b2b_gap", 32'(c2 - c1), 32'(D + 1));
        wait_idle();

        // output stall: result and in_ready held
        out_ready = 1'b0;
        send(8'h99, 8'h96, 0, 0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_wait", {31'd0, out_valid}, 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_sum", 32'(sum_o), 32'h195);
            chk("stall_in_ready", {31'd0, in_ready}, 0);
            chk("stall_out_valid", {31'd0, out_valid}, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // invalid digit, then clean operation clears err
        send(8'h7A, 8'h11, 0, 0);
        send(8'h12, 8'h34, 0, 0);
        wait_idle();

        // reset one edge after acceptance discards the operation
        send(8'h55, 8'h22, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 1);
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_out_valid", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1;
        send(8'h12, 8'h34, 0, 0);
        wait_idle();

`ifdef BCD_SUB_EN
        send(8'h43, 8'h99, 1, 0);
        send(8'h99, 8'h96, 1, 0);
        wait_idle();
`endif

        // random operands, mostly valid digits, random back-pressure
        repeat (40) begin
            for (int i = 0; i < D; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            end
`ifdef BCD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
            send(ra, rb, rs, 1);
        end
        out_ready = 1'b1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
